// File: rtl/commit_perf_monitor_pkg.sv
// Shared definitions for the commit performance monitor.
// Holds the monitor state encoding, the instruction encodings that are
// decoded on the retire stream, the error-bit positions and helpers.
package commit_mon_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FROZEN = 2'd1,
        HALTED = 2'd2
    } mon_state_t;

    localparam logic [31:0] HALT_INST0 = 32'h0000_0063;
    localparam logic [31:0] HALT_INST1 = 32'h0000_006f;
    localparam logic [31:0] HALT_INST2 = 32'hF000_2013;
    localparam logic [31:0] START_MARK = 32'h0010_2013;
    localparam logic [31:0] STOP_MARK  = 32'h0020_2013;

    localparam int ERR_ORDER      = 0;
    localparam int ERR_HOLE       = 1;
    localparam int ERR_AFTER_HALT = 2;

    // Channel count is at most 8, so an 8-bit population count suffices.
    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic is_halt(input logic [31:0] ins);
        return (ins == HALT_INST0) || (ins == HALT_INST1) || (ins == HALT_INST2);
    endfunction

endpackage

// File: rtl/commit_perf_monitor_if.sv
// Retire-port bundle observed by the commit monitor.
//   valid : per-channel commit valid
//   order : packed order numbers, channel c at [c*ORDER_W +: ORDER_W]
//   inst  : packed instructions, channel c at [c*32 +: 32]
// master drives the bundle (ROB side), slave observes it (monitor side).
interface commit_perf_monitor_if #(
    parameter int CHANNELS = 2,
    parameter int ORDER_W  = 64
);
    logic [CHANNELS-1:0]         valid;
    logic [CHANNELS*ORDER_W-1:0] order;
    logic [CHANNELS*32-1:0]      inst;

    modport master (output valid, output order, output inst);
    modport slave  (input  valid, input  order, input  inst);
endinterface

// File: rtl/commit_perf_monitor_order_check.sv
// Commit-stream integrity check: valid-prefix and order continuity.
// Owns the expected-order register; flags are combinational for the
// current cycle and are made sticky by the parent.
//   clk, rst : clock, synchronous active-high reset
//   valid_i  : per-channel commit valid
//   order_i  : packed order numbers
//   gap_o    : some valid channel broke the exp+k sequence this cycle
//   hole_o   : a valid channel sits above an invalid one this cycle
module commit_order_check
    import commit_mon_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int ORDER_W  = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS-1:0]         valid_i,
    input  logic [CHANNELS*ORDER_W-1:0] order_i,
    output logic                        gap_o,
    output logic                        hole_o
);

    logic [ORDER_W-1:0] exp_q, exp_d;
    logic [ORDER_W-1:0] k_c;
    logic               seen_clear_c;
    logic [3:0]         pop_c;

    always_comb begin
        gap_o        = 1'b0;
        hole_o       = 1'b0;
        k_c          = '0;
        seen_clear_c = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (valid_i[c]) begin
                // k counts valid channels, so holes still shift the sequence.
                if (order_i[c*ORDER_W +: ORDER_W] != exp_q + k_c) begin
                    gap_o = 1'b1;
                end
                if (seen_clear_c) begin
                    hole_o = 1'b1;
                end
                k_c = k_c + ORDER_W'(1);
            end else begin
                seen_clear_c = 1'b1;
            end
        end
        pop_c = popcount(8'(valid_i));
        // Natural modulo-2^ORDER_W wrap is intentional.
        exp_d = exp_q + ORDER_W'(pop_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q <= '0;
        end else begin
            exp_q <= exp_d;
        end
    end

endmodule

// File: rtl/commit_perf_monitor.sv
// Commit performance monitor placed beside the ROB retire ports.
// Checks stream integrity, detects halt and keeps marker-delimited
// segment counters plus a per-cycle commit-width histogram.
//   clk, rst    : clock, synchronous active-high reset
//   rt          : retire bundle (slave modport)
//   halt        : sticky halt detected
//   error       : sticky OR of errcode
//   errcode     : sticky [0] order gap, [1] valid hole, [2] commit after halt
//   mon_state   : RUN / FROZEN / HALTED
//   inst_count  : segment instruction count (saturating)
//   cycle_count : segment cycle count (saturating)
//   hist_count  : hist[n] = cycles with exactly n commits, n = 0..CHANNELS
//   seg_done    : one-cycle pulse after a STOP marker is processed
module commit_perf_monitor
    import commit_mon_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int ORDER_W  = 64,
    parameter int CNT_W    = 48
) (
    input  logic                         clk,
    input  logic                         rst,
    commit_perf_monitor_if.slave         rt,
    output logic                         halt,
    output logic                         error,
    output logic [2:0]                   errcode,
    output logic [1:0]                   mon_state,
    output logic [CNT_W-1:0]             inst_count,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [(CHANNELS+1)*CNT_W-1:0] hist_count,
    output logic                         seg_done
);

    // Saturating add of a small increment; needs CNT_W >= 4.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [3:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic             gap_c, hole_c;
    mon_state_t       state_q, state_d;
    logic             halt_q, halt_d;
    logic             error_q, error_d;
    logic [2:0]       errcode_q, errcode_d;
    logic [CNT_W-1:0] inst_q, inst_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] hist_q [CHANNELS+1];
    logic [CNT_W-1:0] hist_d [CHANNELS+1];
    logic             seg_done_q, seg_done_d;

    mon_state_t       st_c;
    logic             tick_c, clr_c, stop_c, halt_c, after_c;
    logic [3:0]       add_c, pop_c;
    logic [31:0]      ins_c;
    logic [CNT_W-1:0] ibase_c, cbase_c, hbase_c;

    commit_order_check #(
        .CHANNELS (CHANNELS),
        .ORDER_W  (ORDER_W)
    ) u_order (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rt.valid),
        .order_i (rt.order),
        .gap_o   (gap_c),
        .hole_o  (hole_c)
    );

    // Walk valid channels in ascending order. tick_c says whether this
    // cycle belongs to the live segment: a START reopens the segment with
    // this cycle excluded, a STOP closes it with this cycle included.
    always_comb begin
        st_c    = state_q;
        tick_c  = (state_q == RUN);
        clr_c   = 1'b0;
        stop_c  = 1'b0;
        halt_c  = 1'b0;
        after_c = 1'b0;
        add_c   = '0;
        ins_c   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ins_c = rt.inst[c*32 +: 32];
            if (rt.valid[c]) begin
                if (halt_q || halt_c) begin
                    after_c = 1'b1;
                end else begin
                    if (ins_c == START_MARK) begin
                        st_c   = RUN;
                        clr_c  = 1'b1;
                        add_c  = '0;
                        tick_c = 1'b0;
                    end else if (st_c == RUN) begin
                        add_c = add_c + 4'd1;
                        if (ins_c == STOP_MARK) begin
                            st_c   = FROZEN;
                            tick_c = 1'b1;
                            stop_c = 1'b1;
                        end
                    end
                    if (is_halt(ins_c)) begin
                        halt_c = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        pop_c      = popcount(8'(rt.valid));
        state_d    = halt_c ? HALTED : st_c;
        halt_d     = halt_q | halt_c;
        errcode_d  = errcode_q;
        errcode_d[ERR_ORDER]      = errcode_q[ERR_ORDER]      | gap_c;
        errcode_d[ERR_HOLE]       = errcode_q[ERR_HOLE]       | hole_c;
        errcode_d[ERR_AFTER_HALT] = errcode_q[ERR_AFTER_HALT] | after_c;
        error_d    = |errcode_d;
        seg_done_d = stop_c;
        ibase_c    = clr_c ? '0 : inst_q;
        cbase_c    = clr_c ? '0 : cyc_q;
        inst_d     = sat_add(ibase_c, add_c);
        cyc_d      = tick_c ? sat_add(cbase_c, 4'd1) : cbase_c;
        hbase_c    = '0;
        for (int n = 0; n <= CHANNELS; n++) begin
            hbase_c   = clr_c ? '0 : hist_q[n];
            hist_d[n] = (tick_c && (pop_c == 4'(n))) ? sat_add(hbase_c, 4'd1) : hbase_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            halt_q     <= 1'b0;
            error_q    <= 1'b0;
            errcode_q  <= '0;
            inst_q     <= '0;
            cyc_q      <= '0;
            seg_done_q <= 1'b0;
            for (int n = 0; n <= CHANNELS; n++) begin
                hist_q[n] <= '0;
            end
        end else begin
            state_q    <= state_d;
            halt_q     <= halt_d;
            error_q    <= error_d;
            errcode_q  <= errcode_d;
            inst_q     <= inst_d;
            cyc_q      <= cyc_d;
            seg_done_q <= seg_done_d;
            for (int n = 0; n <= CHANNELS; n++) begin
                hist_q[n] <= hist_d[n];
            end
        end
    end

    assign halt        = halt_q;
    assign error       = error_q;
    assign errcode     = errcode_q;
    assign mon_state   = state_q;
    assign inst_count  = inst_q;
    assign cycle_count = cyc_q;
    assign seg_done    = seg_done_q;

    for (genvar n = 0; n <= CHANNELS; n++) begin : g_hist
        assign hist_count[n*CNT_W +: CNT_W] = hist_q[n];
    end

endmodule

// File: tb/tb_commit_perf_monitor.sv
// Scoreboard bench for commit_perf_monitor: two instances (wide and a
// narrow 4-bit-order / 4-bit-counter one) see the same retire stream.
module tb_commit_perf_monitor;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] START = 32'h0010_2013;
    localparam logic [31:0] STOP  = 32'h0020_2013;
    localparam logic [31:0] HALTS [3] = '{32'h0000_0063, 32'h0000_006f, 32'hF000_2013};

    typedef struct packed {
        logic        halt;
        logic        err;
        logic [2:0]  code;
        logic [1:0]  st;
        logic [63:0] inst;
        logic [63:0] cyc;
        logic [63:0] h0;
        logic [63:0] h1;
        logic [63:0] h2;
        logic        sd;
    } exp_t;

    typedef struct packed {
        logic [31:0] due;
        exp_t        a;
        exp_t        b;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    commit_perf_monitor_if #(.CHANNELS(2), .ORDER_W(64)) ifa ();
    commit_perf_monitor_if #(.CHANNELS(2), .ORDER_W(4))  ifb ();

    logic        halt_a, err_a, sd_a, halt_b, err_b, sd_b;
    logic [2:0]  code_a, code_b;
    logic [1:0]  st_a, st_b;
    logic [47:0] inst_a, cyc_a;
    logic [143:0] hist_a;
    logic [3:0]  inst_b, cyc_b;
    logic [11:0] hist_b;

    commit_perf_monitor #(.CHANNELS(2), .ORDER_W(64), .CNT_W(48)) dut_a (
        .clk(clk), .rst(rst), .rt(ifa), .halt(halt_a), .error(err_a), .errcode(code_a),
        .mon_state(st_a), .inst_count(inst_a), .cycle_count(cyc_a), .hist_count(hist_a),
        .seg_done(sd_a));

    commit_perf_monitor #(.CHANNELS(2), .ORDER_W(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .rt(ifb), .halt(halt_b), .error(err_b), .errcode(code_b),
        .mon_state(st_b), .inst_count(inst_b), .cycle_count(cyc_b), .hist_count(hist_b),
        .seg_done(sd_b));

    int checks = 0;
    int errors = 0;
    logic [31:0] cyc = 0;
    entry_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic cmp(input string t, input exp_t x, input exp_t y);
        chk({t, "_halt"},     64'(x.halt), 64'(y.halt));
        chk({t, "_error"},    64'(x.err),  64'(y.err));
        chk({t, "_errcode"},  64'(x.code), 64'(y.code));
        chk({t, "_state"},    64'(x.st),   64'(y.st));
        chk({t, "_inst"},     x.inst, y.inst);
        chk({t, "_cycle"},    x.cyc,  y.cyc);
        chk({t, "_hist0"},    x.h0,   y.h0);
        chk({t, "_hist1"},    x.h1,   y.h1);
        chk({t, "_hist2"},    x.h2,   y.h2);
        chk({t, "_seg_done"}, 64'(x.sd),   64'(y.sd));
    endtask

    // Monitor: outputs for inputs driven before an edge are checked just after it.
    always @(posedge clk) begin
        exp_t aa, bb;
        entry_t e;
        #1;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            aa = '{halt_a, err_a, code_a, st_a, 64'(inst_a), 64'(cyc_a),
                   64'(hist_a[0 +: 48]), 64'(hist_a[48 +: 48]), 64'(hist_a[96 +: 48]), sd_a};
            bb = '{halt_b, err_b, code_b, st_b, 64'(inst_b), 64'(cyc_b),
                   64'(hist_b[0 +: 4]), 64'(hist_b[4 +: 4]), 64'(hist_b[8 +: 4]), sd_b};
            cmp("a", aa, e.a);
            cmp("b", bb, e.b);
        end
    end

    // Reference model: segment bookkeeping straight from the commit rules.
    logic [63:0] cap   [2] = '{64'hFFFF_FFFF_FFFF, 64'hF};
    logic [63:0] omask [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hF};
    logic [63:0] m_exp [2], m_inst [2], m_cyc [2];
    logic [63:0] m_hist [2][3];
    logic [2:0]  m_err [2];
    bit          m_halt [2], m_sd [2];
    int          m_st [2];

    function automatic logic [63:0] satc(input int i, input logic [63:0] x);
        return (x > cap[i]) ? cap[i] : x;
    endfunction

    function automatic bit is_h(input logic [31:0] x);
        return x == HALTS[0] || x == HALTS[1] || x == HALTS[2];
    endfunction

    task automatic model_step(input int i, input logic r, input logic [1:0] v,
                              input logic [63:0] o0, input logic [63:0] o1,
                              input logic [31:0] i0, input logic [31:0] i1, output exp_t e);
        logic [63:0] ord [2];
        logic [31:0] ins [2];
        int vl[$];
        int live, hpos, n;
        bit cleared, counted;
        if (r) begin
            m_exp[i] = 0; m_inst[i] = 0; m_cyc[i] = 0; m_err[i] = 0;
            m_halt[i] = 0; m_sd[i] = 0; m_st[i] = 0;
            for (int h = 0; h < 3; h++) m_hist[i][h] = 0;
        end else begin
            ord[0] = o0 & omask[i]; ord[1] = o1 & omask[i];
            ins[0] = i0; ins[1] = i1;
            for (int c = 0; c < 2; c++) if (v[c]) vl.push_back(c);
            if (v == 2'b10) m_err[i][1] = 1'b1;
            foreach (vl[k]) if (ord[vl[k]] != ((m_exp[i] + 64'(k)) & omask[i])) m_err[i][0] = 1'b1;
            m_exp[i] = (m_exp[i] + 64'(vl.size())) & omask[i];
            m_sd[i] = 0;
            live = vl.size();
            hpos = -1;
            if (m_halt[i]) begin
                if (vl.size() > 0) m_err[i][2] = 1'b1;
                live = 0;
            end else begin
                foreach (vl[k]) if (hpos < 0 && is_h(ins[vl[k]])) hpos = k;
                if (hpos >= 0) begin
                    live = hpos + 1;
                    if (vl.size() > live) m_err[i][2] = 1'b1;
                end
            end
            cleared = 0; counted = (m_st[i] == 0); n = 0;
            for (int k = 0; k < live; k++) begin
                if (ins[vl[k]] == START) begin
                    m_st[i] = 0; cleared = 1; n = 0; counted = 0;
                end else if (m_st[i] == 0) begin
                    n++;
                    if (ins[vl[k]] == STOP) begin m_st[i] = 1; counted = 1; m_sd[i] = 1; end
                end
            end
            if (hpos >= 0) begin m_halt[i] = 1; m_st[i] = 2; end
            if (cleared) begin
                m_inst[i] = 0; m_cyc[i] = 0;
                for (int h = 0; h < 3; h++) m_hist[i][h] = 0;
            end
            m_inst[i] = satc(i, m_inst[i] + 64'(n));
            if (counted) begin
                m_cyc[i] = satc(i, m_cyc[i] + 1);
                m_hist[i][vl.size()] = satc(i, m_hist[i][vl.size()] + 1);
            end
        end
        e = '{m_halt[i], |m_err[i], m_err[i], 2'(m_st[i]), m_inst[i], m_cyc[i],
              m_hist[i][0], m_hist[i][1], m_hist[i][2], m_sd[i]};
    endtask

    task automatic drive(input logic r, input logic [1:0] v, input logic [63:0] o0,
                         input logic [63:0] o1, input logic [31:0] i0, input logic [31:0] i1);
        entry_t e;
        @(negedge clk);
        rst = r;
        ifa.valid = v; ifa.order = {o1, o0}; ifa.inst = {i1, i0};
        ifb.valid = v; ifb.order = {o1[3:0], o0[3:0]}; ifb.inst = {i1, i0};
        model_step(0, r, v, o0, o1, i0, i1, e.a);
        model_step(1, r, v, o0, o1, i0, i1, e.b);
        e.due = cyc + 1;
        sbq.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 64'd0, 64'd0, NOP, NOP);
    endtask

    task automatic spot_wait();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] gen;

    initial begin
        ifa.valid = '0; ifa.order = '0; ifa.inst = '0;
        ifb.valid = '0; ifb.order = '0; ifb.inst = '0;

        // Two back-to-back pairs then two idle cycles.
        drive(1'b1, 2'b00, 0, 0, NOP, NOP);
        drive(1'b0, 2'b11, 0, 1, NOP, NOP);
        drive(1'b0, 2'b11, 2, 3, NOP, NOP);
        idle(); idle();
        spot_wait();
        chk("tp1_inst", 64'(inst_a), 4);
        chk("tp1_cycle", 64'(cyc_a), 4);
        chk("tp1_hist0", 64'(hist_a[0 +: 48]), 2);
        chk("tp1_hist2", 64'(hist_a[96 +: 48]), 2);
        chk("tp1_errcode", 64'(code_a), 0);

        // START on ch0 with ch1 valid, then idle.
        drive(1'b1, 2'b00, 0, 0, NOP, NOP);
        drive(1'b0, 2'b11, 0, 1, START, NOP);
        idle(); idle(); idle();
        spot_wait();
        chk("tp2_inst", 64'(inst_a), 1);
        chk("tp2_cycle", 64'(cyc_a), 3);
        chk("tp2_hist1", 64'(hist_a[48 +: 48]), 0);
        chk("tp2_hist0", 64'(hist_a[0 +: 48]), 3);

        // STOP on ch0 with ch1 valid; later commits must not move counters.
        drive(1'b1, 2'b00, 0, 0, NOP, NOP);
        drive(1'b0, 2'b11, 0, 1, STOP, NOP);
        spot_wait();
        chk("tp3_inst", 64'(inst_a), 1);
        chk("tp3_state", 64'(st_a), 1);
        chk("tp3_seg_done", 64'(sd_a), 1);
        for (int k = 0; k < 5; k++) drive(1'b0, 2'b01, 64'(2 + k), 0, NOP, NOP);
        spot_wait();
        chk("tp3_inst_hold", 64'(inst_a), 1);
        chk("tp3_seg_done_low", 64'(sd_a), 0);

        // Order jump 7 -> 9, then a valid hole.
        drive(1'b1, 2'b00, 0, 0, NOP, NOP);
        for (int k = 0; k < 8; k++) drive(1'b0, 2'b01, 64'(k), 0, NOP, NOP);
        drive(1'b0, 2'b01, 9, 0, NOP, NOP);
        drive(1'b0, 2'b10, 0, 9, NOP, NOP);
        idle(); idle();
        spot_wait();
        chk("tp4_errcode", 64'(code_a), 3);
        chk("tp4_error", 64'(err_a), 1);

        // Halt on ch0 with ch1 valid, then a late commit.
        drive(1'b1, 2'b00, 0, 0, NOP, NOP);
        drive(1'b0, 2'b11, 0, 1, HALTS[1], NOP);
        spot_wait();
        chk("tp5_halt", 64'(halt_a), 1);
        chk("tp5_state", 64'(st_a), 2);
        chk("tp5_errcode", 64'(code_a), 4);
        drive(1'b0, 2'b01, 2, 0, NOP, NOP);
        idle();

        // Narrow instance: counters saturate, order wraps; then reset mid-segment.
        drive(1'b1, 2'b00, 0, 0, NOP, NOP);
        for (int k = 0; k < 20; k++) drive(1'b0, 2'b01, 64'(k), 0, NOP, NOP);
        spot_wait();
        chk("tp6_cycle_sat", 64'(cyc_b), 15);
        chk("tp6_inst_sat", 64'(inst_b), 15);
        chk("tp6_wrap_errcode", 64'(code_b), 0);
        chk("tp6_cycle_wide", 64'(cyc_a), 20);
        drive(1'b1, 2'b11, 20, 21, START, STOP);
        spot_wait();
        chk("tp6_rst_inst", 64'(inst_a), 0);
        chk("tp6_rst_cycle", 64'(cyc_a), 0);
        chk("tp6_rst_cycle_b", 64'(cyc_b), 0);
        chk("tp6_rst_hist0", 64'(hist_a[0 +: 48]), 0);

        // Randomised stream.
        gen = 0;
        for (int t = 0; t < 2000; t++) begin
            logic [1:0]  v;
            logic [63:0] o [2];
            logic [31:0] ins [2];
            int x, k;
            bit r;
            r = ($urandom_range(0, 99) < (m_halt[0] ? 15 : 2));
            x = $urandom_range(0, 19);
            v = (x < 4) ? 2'b00 : (x < 10) ? 2'b01 : (x < 19) ? 2'b11 : 2'b10;
            k = 0;
            for (int c = 0; c < 2; c++) begin
                o[c] = 64'($urandom);
                if (v[c]) begin
                    o[c] = gen + 64'(k);
                    if ($urandom_range(0, 99) < 3) o[c] = o[c] + 64'($urandom_range(1, 2));
                    k++;
                end
                x = $urandom_range(0, 99);
                ins[c] = (x < 8) ? START : (x < 16) ? STOP :
                         (x < 17) ? HALTS[$urandom_range(0, 2)] : $urandom;
            end
            gen = r ? 64'd0 : gen + 64'(k);
            drive(r, v, o[0], o[1], ins[0], ins[1]);
        end

        idle(); idle(); idle();
        @(posedge clk); #2;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
